pipe_stage_buffer: RTL

Parametrised inter-stage pipeline register that replaces the fixed-width, free-running stage buffers between processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data payload and a control bundle with a valid/ready handshake, so a downstream stall holds the stage instead of overwriting it. A 2-entry skid keeps full throughput while in_ready stays registered. Flush converts the stage into a bubble with all-zero outputs, as the existing buffers do.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_buffer_slot.sv | 24 ++
 rtl/pipe_stage_buffer.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers.
package pipe_pkg;

    localparam int unsigned ID_EX_DATA_W = 160;
    localparam int unsigned ID_EX_CTRL_W = 13;

    // Occupancy state; the encoding is the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_buffer_slot.sv
// One buffer slot: W-bit register plus valid bit, clear wins over load.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage register with a 2-entry skid and bubble-on-flush.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned CTRL_W = ID_EX_CTRL_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int unsigned SLOT_W = DATA_W + CTRL_W;

    occ_e              state;
    logic              accept;
    logic              drain;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [SLOT_W-1:0] main_d;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;
    logic              skid_valid;

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

    // Occupancy FSM; in_ready is registered from the next occupancy.
    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            state    <= OCC_EMPTY;
            in_ready <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) state <= OCC_ONE;
                end
                OCC_ONE: begin
                    if (accept && !drain) begin
                        state    <= OCC_TWO;
                        in_ready <= 1'b0;
                    end else if (!accept && drain) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (drain) begin
                        state    <= OCC_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= OCC_EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Slot steering: MAIN refills from SKID whenever SKID holds the older entry.
    always_comb begin
        main_load  = 1'b0;
        main_clear = flush;
        skid_load  = 1'b0;
        skid_clear = flush;
        main_d     = skid_valid ? skid_q : {in_ctrl, in_data};
        case (state)
            OCC_EMPTY: main_load = accept;
            OCC_ONE: begin
                main_load  = accept & drain;
                skid_load  = accept & ~drain;
                main_clear = flush | (drain & ~accept);
            end
            OCC_TWO: begin
                main_load  = drain;
                skid_clear = flush | drain;
            end
            default: main_clear = 1'b1;
        endcase
    end

    pipe_slot #(.W(SLOT_W)) u_main (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .valid (out_valid)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_ctrl, in_data}),
        .q     (skid_q),
        .valid (skid_valid)
    );

    assign out_data  = main_q[DATA_W-1:0];
    assign out_ctrl  = main_q[SLOT_W-1:DATA_W];
    assign occupancy = state;

endmodule
